pay_terminal_arbiter: RTL and testbench

Shares one payment terminal between NLANES gate lanes, each driven by its own smart gate controller. A lane requests while a car waits. The arbiter grants the terminal round-robin, sequences the start/done handshake, and returns a one-cycle pay OK or pay fail pulse to the granted lane. It also keeps a saturating count of successful payments.

---
 rtl/pay_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 30 +++
 rtl/pay_terminal_arbiter.sv | 134 +++++++++++++
 tb/tb_pay_terminal_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pay_arb_pkg.sv
// rtl/pay_arb_pkg.sv - shared state encoding and constants for the payment terminal arbiter
package pay_arb_pkg;

  localparam int         NLANES_MAX = 8;
  localparam logic [7:0] CNT_MAX    = 8'd255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    BUSY   = 2'd2,
    REPORT = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin chooser, search starts one past ptr and wraps
module rr_picker
  import pay_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] ptr,
  output logic          valid,
  output logic [LW-1:0] lane
);

  logic [LW-1:0] cand;

  // Walk from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    valid = 1'b0;
    lane  = '0;
    cand  = '0;
    for (int i = N; i >= 1; i--) begin
      cand = LW'((int'(ptr) + i) % N);
      if (req[cand]) begin
        valid = 1'b1;
        lane  = cand;
      end
    end
  end

endmodule

// File: rtl/pay_terminal_arbiter.sv
// rtl/pay_terminal_arbiter.sv - round-robin sharing of one payment terminal between gate lanes
// Optional BUSY timeout built when PAY_ARB_TIMEOUT_EN is defined.
module pay_terminal_arbiter
  import pay_arb_pkg::*;
#(
  parameter int NLANES  = 4,
  parameter int TIMEOUT = 200,
  parameter int LANE_W  = $clog2(NLANES)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [NLANES-1:0] req_i,
  input  logic              term_done_i,
  input  logic              term_ok_i,
  input  logic              cnt_reset_i,
  output logic              term_start_o,
  output logic              term_abort_o,
  output logic [LANE_W-1:0] term_lane_o,
  output logic [NLANES-1:0] grant_o,
  output logic [NLANES-1:0] pay_ok_o,
  output logic [NLANES-1:0] pay_fail_o,
  output logic              busy_o,
  output logic [7:0]        served_cnt_o
);

  localparam logic [LANE_W-1:0] PTR_RST = LANE_W'(NLANES - 1);

  arb_state_e        state_q, state_n;
  logic [LANE_W-1:0] lane_q, lane_n;
  logic [LANE_W-1:0] ptr_q, ptr_n;
  logic [LANE_W-1:0] pick_lane;
  logic              pick_valid;
  logic              result_q, result_n;
  logic              abort_q, abort_n;
  logic              timeout_hit;
  logic [7:0]        cnt_q;
  logic [NLANES-1:0] lane_oh;

  rr_picker #(.N(NLANES), .LW(LANE_W)) u_picker (
    .req   (req_i),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .lane  (pick_lane)
  );

`ifdef PAY_ARB_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt_q;

  always_ff @(negedge clk_i or negedge reset_ni) begin
    if (!reset_ni)              tcnt_q <= '0;
    else if (state_q == BUSY)   tcnt_q <= tcnt_q + 1'b1;
    else                        tcnt_q <= '0;
  end

  assign timeout_hit = (tcnt_q == T_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_n  = state_q;
    lane_n   = lane_q;
    ptr_n    = ptr_q;
    result_n = result_q;
    abort_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          lane_n  = pick_lane;
          state_n = START;
        end
      end
      START: state_n = BUSY;
      BUSY: begin
        if (term_done_i) begin
          result_n = term_ok_i;
          state_n  = REPORT;
        end else if (!req_i[lane_q]) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else if (timeout_hit) begin
          abort_n  = 1'b1;
          result_n = 1'b0;
          state_n  = REPORT;
        end
      end
      REPORT: begin
        ptr_n   = lane_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(negedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      ptr_q    <= PTR_RST;
      result_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      lane_q   <= lane_n;
      ptr_q    <= ptr_n;
      result_q <= result_n;
      abort_q  <= abort_n;
    end
  end

  // Clear wins over a coinciding successful report.
  always_ff @(negedge clk_i or negedge reset_ni) begin
    if (!reset_ni)
      cnt_q <= '0;
    else if (cnt_reset_i)
      cnt_q <= '0;
    else if (state_q == REPORT && result_q && cnt_q != CNT_MAX)
      cnt_q <= cnt_q + 8'd1;
  end

  assign lane_oh      = {{(NLANES-1){1'b0}}, 1'b1} << lane_q;
  assign busy_o       = (state_q != IDLE);
  assign term_start_o = (state_q == START);
  assign term_abort_o = abort_q;
  assign term_lane_o  = busy_o ? lane_q : '0;
  assign grant_o      = busy_o ? lane_oh : '0;
  assign pay_ok_o     = (state_q == REPORT &&  result_q) ? lane_oh : '0;
  assign pay_fail_o   = (state_q == REPORT && !result_q) ? lane_oh : '0;
  assign served_cnt_o = cnt_q;

endmodule

// File: tb/tb_pay_terminal_arbiter.sv
// tb/tb_pay_terminal_arbiter.sv - vector-table and directed checks for pay_terminal_arbiter
module tb_pay_terminal_arbiter;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic [3:0] req_i;
  logic       term_done_i, term_ok_i, cnt_reset_i;
  logic       term_start_o, term_abort_o, busy_o;
  logic [1:0] term_lane_o;
  logic [3:0] grant_o, pay_ok_o, pay_fail_o;
  logic [7:0] served_cnt_o;

  always #5 clk = ~clk;

  pay_terminal_arbiter #(.NLANES(4), .TIMEOUT(5)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .req_i        (req_i),
    .term_done_i  (term_done_i),
    .term_ok_i    (term_ok_i),
    .cnt_reset_i  (cnt_reset_i),
    .term_start_o (term_start_o),
    .term_abort_o (term_abort_o),
    .term_lane_o  (term_lane_o),
    .grant_o      (grant_o),
    .pay_ok_o     (pay_ok_o),
    .pay_fail_o   (pay_fail_o),
    .busy_o       (busy_o),
    .served_cnt_o (served_cnt_o)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic        done;
    logic        ok;
    logic        clr;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // {grant, start, abort, pay_ok, pay_fail, busy, lane, cnt}
  function automatic logic [24:0] ex(input logic [3:0] g, input logic st, input logic ab,
                                     input logic [3:0] po, input logic [3:0] pf,
                                     input logic bz, input logic [1:0] ln, input logic [7:0] c);
    return {g, st, ab, po, pf, bz, ln, c};
  endfunction

  function automatic logic [24:0] idle(input logic [7:0] c);
    return ex(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, c);
  endfunction

  function automatic logic [24:0] act();
    return {grant_o, term_start_o, term_abort_o, pay_ok_o, pay_fail_o, busy_o, term_lane_o, served_cnt_o};
  endfunction

  function automatic void add(input logic rn, input logic [3:0] rq, input logic d, input logic o,
                              input logic c, input logic [24:0] e);
    vec_t v;
    v.rst_n = rn; v.req = rq; v.done = d; v.ok = o; v.clr = c; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic apply(input logic rn, input logic [3:0] rq, input logic d, input logic o, input logic c);
    reset_ni = rn; req_i = rq; term_done_i = d; term_ok_i = o; cnt_reset_i = c;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [24:0] a, input logic [24:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic txn(input logic clr_at_end);
    apply(1, 4'b0001, 0, 0, 0);
    apply(1, 4'b0001, 0, 0, 0);
    apply(1, 4'b0001, 1, 1, 0);
    apply(1, 4'b0000, 0, 0, clr_at_end);
  endtask

  initial begin
    int          order[5];
    logic [3:0]  oh;
    reset_ni = 1'b0; req_i = '0; term_done_i = 1'b0; term_ok_i = 1'b0; cnt_reset_i = 1'b0;

    // reset
    add(0, 4'b0000, 0, 0, 0, idle(0));
    add(0, 4'b0000, 0, 0, 0, idle(0));
    // lane 0 single success
    add(1, 4'b0001, 0, 0, 0, ex(4'b0001, 1, 0, 4'b0000, 4'b0000, 1, 2'd0, 0));
    add(1, 4'b0001, 0, 0, 0, ex(4'b0001, 0, 0, 4'b0000, 4'b0000, 1, 2'd0, 0));
    add(1, 4'b0001, 0, 0, 0, ex(4'b0001, 0, 0, 4'b0000, 4'b0000, 1, 2'd0, 0));
    add(1, 4'b0001, 0, 0, 0, ex(4'b0001, 0, 0, 4'b0000, 4'b0000, 1, 2'd0, 0));
    add(1, 4'b0001, 1, 1, 0, ex(4'b0001, 0, 0, 4'b0001, 4'b0000, 1, 2'd0, 0));
    add(1, 4'b0000, 0, 0, 0, idle(1));
    add(1, 4'b0000, 1, 1, 0, idle(1));
    // lane 2 failure, done during START ignored
    add(1, 4'b0100, 0, 0, 0, ex(4'b0100, 1, 0, 4'b0000, 4'b0000, 1, 2'd2, 1));
    add(1, 4'b0100, 1, 0, 0, ex(4'b0100, 0, 0, 4'b0000, 4'b0000, 1, 2'd2, 1));
    add(1, 4'b0100, 1, 0, 0, ex(4'b0100, 0, 0, 4'b0000, 4'b0100, 1, 2'd2, 1));
    add(1, 4'b0000, 0, 0, 0, idle(1));
    // lane 3 withdraws in BUSY
    add(1, 4'b1000, 0, 0, 0, ex(4'b1000, 1, 0, 4'b0000, 4'b0000, 1, 2'd3, 1));
    add(1, 4'b1000, 0, 0, 0, ex(4'b1000, 0, 0, 4'b0000, 4'b0000, 1, 2'd3, 1));
    add(1, 4'b0000, 0, 0, 0, ex(4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 2'd0, 1));
    add(1, 4'b0000, 0, 0, 0, idle(1));
    // done and withdraw together: report wins
    add(1, 4'b1000, 0, 0, 0, ex(4'b1000, 1, 0, 4'b0000, 4'b0000, 1, 2'd3, 1));
    add(1, 4'b1000, 0, 0, 0, ex(4'b1000, 0, 0, 4'b0000, 4'b0000, 1, 2'd3, 1));
    add(1, 4'b0000, 1, 1, 0, ex(4'b1000, 0, 0, 4'b1000, 4'b0000, 1, 2'd3, 1));
    add(1, 4'b0000, 0, 0, 0, idle(2));
    // pointer at 3: lanes 1,2 requesting -> lane 1, then back-to-back lane 2
    add(1, 4'b0110, 0, 0, 0, ex(4'b0010, 1, 0, 4'b0000, 4'b0000, 1, 2'd1, 2));
    add(1, 4'b0110, 0, 0, 0, ex(4'b0010, 0, 0, 4'b0000, 4'b0000, 1, 2'd1, 2));
    add(1, 4'b0110, 1, 1, 0, ex(4'b0010, 0, 0, 4'b0010, 4'b0000, 1, 2'd1, 2));
    add(1, 4'b0100, 0, 0, 0, idle(3));
    add(1, 4'b0100, 0, 0, 0, ex(4'b0100, 1, 0, 4'b0000, 4'b0000, 1, 2'd2, 3));
    add(1, 4'b0100, 0, 0, 0, ex(4'b0100, 0, 0, 4'b0000, 4'b0000, 1, 2'd2, 3));
    add(1, 4'b0000, 0, 0, 0, ex(4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 2'd0, 3));
    // reset, then all lanes held: served 0,1,2,3,0
    add(0, 4'b0000, 0, 0, 0, idle(0));
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << order[k];
      add(1, 4'b1111, 0, 0, 0, ex(oh, 1, 0, 4'b0000, 4'b0000, 1, 2'(order[k]), 8'(k)));
      add(1, 4'b1111, 0, 0, 0, ex(oh, 0, 0, 4'b0000, 4'b0000, 1, 2'(order[k]), 8'(k)));
      add(1, 4'b1111, 1, 1, 0, ex(oh, 0, 0, oh, 4'b0000, 1, 2'(order[k]), 8'(k)));
      add(1, 4'b1111, 0, 0, 0, idle(8'(k + 1)));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst_n, tbl[i].req, tbl[i].done, tbl[i].ok, tbl[i].clr);
      check($sformatf("vec%0d", i), act(), tbl[i].exp);
    end

    // BUSY with no done: timeout path or indefinite wait
    apply(1, 4'b0001, 0, 0, 0);
    check("to_start", act(), ex(4'b0001, 1, 0, 4'b0000, 4'b0000, 1, 2'd0, 5));
`ifdef PAY_ARB_TIMEOUT_EN
    for (int i = 1; i <= 5; i++) begin
      apply(1, 4'b0001, 0, 0, 0);
      check($sformatf("to_busy%0d", i), act(), ex(4'b0001, 0, 0, 4'b0000, 4'b0000, 1, 2'd0, 5));
    end
    apply(1, 4'b0001, 0, 0, 0);
    check("to_report", act(), ex(4'b0001, 0, 1, 4'b0000, 4'b0001, 1, 2'd0, 5));
    apply(1, 4'b0000, 0, 0, 0);
    check("to_idle", act(), idle(5));
`else
    for (int i = 1; i <= 50; i++) apply(1, 4'b0001, 0, 0, 0);
    check("busy_after_50", act(), ex(4'b0001, 0, 0, 4'b0000, 4'b0000, 1, 2'd0, 5));
    apply(1, 4'b0000, 0, 0, 0);
    check("late_withdraw", act(), ex(4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 2'd0, 5));
`endif

    // async reset in BUSY
    apply(1, 4'b0001, 0, 0, 0);
    apply(1, 4'b0001, 0, 0, 0);
    check("pre_rst_busy", act(), ex(4'b0001, 0, 0, 4'b0000, 4'b0000, 1, 2'd0, 5));
    reset_ni = 1'b0;
    #1;
    check("rst_immediate", act(), idle(0));
    apply(0, 4'b0001, 0, 0, 0);
    check("rst_no_abort", act(), idle(0));

    // saturation
    for (int i = 0; i < 255; i++) txn(1'b0);
    check("cnt_255", act(), idle(255));
    txn(1'b0);
    check("cnt_sat", act(), idle(255));

    // clear alone, then clear against a successful report
    apply(1, 4'b0000, 0, 0, 1);
    check("clr_idle", act(), idle(0));
    txn(1'b0);
    check("cnt_after_clr", act(), idle(1));
    txn(1'b1);
    check("clr_beats_inc", act(), idle(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
